// File: rtl/imem_pkg.sv
// Shared types and helpers for the loadable instruction memory:
// load FSM states, fetch-fault reasons and byte-address to word-index decode.
package imem_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int ADDR_MAX_W     = 64;

  localparam logic [1:0] FLT_NONE  = 2'd0;
  localparam logic [1:0] FLT_ALIGN = 2'd1;
  localparam logic [1:0] FLT_UNDER = 2'd2;
  localparam logic [1:0] FLT_RANGE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMMIT
  } imem_state_t;

  typedef struct packed {
    logic [ADDR_MAX_W-1:0] idx;
    logic                  ok;
  } fetch_chk_t;

  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int bpw_log2(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Alignment is judged on the offset; the base is word-aligned, so both views agree.
  function automatic fetch_chk_t addr_to_idx(input logic [ADDR_MAX_W-1:0] a,
                                             input logic [ADDR_MAX_W-1:0] base,
                                             input int unsigned depth,
                                             input int unsigned shift);
    fetch_chk_t r;
    logic [ADDR_MAX_W-1:0] off;
    logic [ADDR_MAX_W-1:0] mask;
    logic [1:0] reason;
    off   = a - base;
    mask  = (ADDR_MAX_W'(1) << shift) - ADDR_MAX_W'(1);
    r.idx = off >> shift;
    if ((off & mask) != '0)               reason = FLT_ALIGN;
    else if (a < base)                    reason = FLT_UNDER;
    else if (r.idx >= ADDR_MAX_W'(depth)) reason = FLT_RANGE;
    else                                  reason = FLT_NONE;
    r.ok = (reason == FLT_NONE);
    return r;
  endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Assembles little-endian program bytes into instruction words and strobes
// when a word is complete or the image ends early (upper bytes left zero).
module imem_byte_packer
  import imem_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [7:0]        byte_in,
  input  logic              last,
  output logic [DATA_W-1:0] word,
  output logic              word_stb
);

  localparam int BPW  = bytes_per_word(DATA_W);
  localparam int BI_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [BI_W-1:0]   byte_idx;
  logic [DATA_W-1:0] asm_q;
  logic              full;

  always_comb begin
    word = asm_q;
    word[{byte_idx, 3'b000} +: 8] = byte_in;
  end

  assign full     = (byte_idx == BI_W'(BPW - 1));
  assign word_stb = shift_en && (full || last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx <= '0;
      asm_q    <= '0;
    end else if (clear) begin
      byte_idx <= '0;
      asm_q    <= '0;
    end else if (shift_en) begin
      if (word_stb) begin
        byte_idx <= '0;
        asm_q    <= '0;
      end else begin
        byte_idx <= byte_idx + BI_W'(1);
        asm_q    <= word;
      end
    end
  end

endmodule

// File: rtl/instr_mem_prog.sv
// Runtime-loadable instruction memory: registered fetch port plus byte-serial loader.
// Define IMEM_PARITY_EN to store an even-parity bit per word and expose sticky par_err.
module instr_mem_prog
  import imem_pkg::*;
#(
  parameter int                DATA_W    = DEFAULT_DATA_W,
  parameter int                DEPTH     = 64,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] RA,
  output logic              RA_valid,
  output logic              fault,
  input  logic              prog_start,
  input  logic              prog_valid,
  input  logic [7:0]        prog_byte,
  input  logic              prog_last,
  output logic              busy,
  output logic              prog_done,
  output logic              prog_ovf
`ifdef IMEM_PARITY_EN
  ,
  output logic              par_err
`endif
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int WIDX_W = IDX_W + 1;
  localparam int SHIFT  = bpw_log2(DATA_W);
`ifdef IMEM_PARITY_EN
  localparam int MEM_W  = DATA_W + 1;
`else
  localparam int MEM_W  = DATA_W;
`endif

  imem_state_t       state;
  logic [WIDX_W-1:0] word_idx;
  logic              start_ev, load_en, accept, word_stb, wr_en;
  logic              rd_ok, par_bad;
  logic [DATA_W-1:0] word;
  logic [MEM_W-1:0]  wr_data, rd_data;
  logic [MEM_W-1:0]  mem [DEPTH];
  fetch_chk_t        chk;

  // prog_start is ignored during the single COMMIT cycle.
  assign start_ev = prog_start && (state != ST_COMMIT);
  assign load_en  = prog_valid && (state == ST_LOAD) && !prog_start;
  assign accept   = fetch_req && (state == ST_IDLE);
  assign chk      = addr_to_idx(ADDR_MAX_W'(A), ADDR_MAX_W'(BASE_ADDR), DEPTH, SHIFT);
  assign wr_en    = word_stb && (word_idx < WIDX_W'(DEPTH));

  imem_byte_packer #(.DATA_W(DATA_W)) u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_ev),
    .shift_en (load_en),
    .byte_in  (prog_byte),
    .last     (prog_last),
    .word     (word),
    .word_stb (word_stb)
  );

`ifdef IMEM_PARITY_EN
  assign wr_data = {^word, word};
  assign par_bad = ^rd_data;
`else
  assign wr_data = word;
  assign par_bad = 1'b0;
`endif

  assign rd_data = mem[IDX_W'(chk.idx)];
  assign rd_ok   = chk.ok && !par_bad;

  always_ff @(posedge clk) begin
    if (wr_en) mem[word_idx[IDX_W-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RA       <= '0;
      RA_valid <= 1'b0;
      fault    <= 1'b0;
`ifdef IMEM_PARITY_EN
      par_err  <= 1'b0;
`endif
    end else begin
      RA_valid <= accept;
      if (accept) begin
        RA    <= rd_ok ? rd_data[DATA_W-1:0] : '0;
        fault <= !rd_ok;
      end
`ifdef IMEM_PARITY_EN
      if (start_ev) par_err <= 1'b0;
      if (accept && chk.ok && par_bad) par_err <= 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      word_idx  <= '0;
      busy      <= 1'b0;
      prog_done <= 1'b0;
      prog_ovf  <= 1'b0;
    end else begin
      prog_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (prog_start) begin
            state    <= ST_LOAD;
            busy     <= 1'b1;
            word_idx <= '0;
            prog_ovf <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (prog_start) begin
            word_idx <= '0;
            prog_ovf <= 1'b0;
          end else begin
            // Index saturates at DEPTH; further words are dropped and flagged.
            if (word_stb) begin
              if (wr_en) word_idx <= word_idx + WIDX_W'(1);
              else       prog_ovf <= 1'b1;
            end
            if (prog_valid && prog_last) begin
              state     <= ST_COMMIT;
              prog_done <= 1'b1;
            end
          end
        end
        ST_COMMIT: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/instr_mem_prog.md
Name: instr_mem_prog

Overview:
Parametrised, runtime-loadable instruction memory for the ARM calculator core. It replaces a hard-coded combinational program ROM with a synchronous word array: one registered fetch port on the processor side, and a byte-serial program-load port driven by the host/UART loader. The block adds fetch handshaking, address-range and alignment fault detection, and a load state machine that blocks fetches while the array is being rewritten.

Parameters:
DATA_W, 32, instruction word width; multiple of 8.
DEPTH, 64, number of instruction words; power of two, 4..4096.
ADDR_W, 32, byte-address width of A.
BASE_ADDR, 32'h00000004, byte address of word 0; word-aligned.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
fetch_req  in  1  processor fetch request.
A  in  ADDR_W  fetch byte address.
RA  out  DATA_W  fetched instruction, registered.
RA_valid  out  1  RA holds the result of the previous accepted fetch.
fault  out  1  previous accepted fetch was out of range or misaligned; RA=0.
prog_start  in  1  one-cycle pulse that begins a load session at word 0.
prog_valid  in  1  prog_byte is valid this cycle.
prog_byte  in  8  program byte, little-endian within a word.
prog_last  in  1  qualifies prog_valid: final byte of the image.
busy  out  1  load session active; fetches are not accepted.
prog_done  out  1  one-cycle pulse when the session closes.
prog_ovf  out  1  sticky: a write was attempted beyond DEPTH; cleared by prog_start.

Behaviour:
- Reset values: RA=0, RA_valid=0, fault=0, busy=0, prog_done=0, prog_ovf=0, FSM=IDLE, word index=0, byte index=0.
- Array contents are not reset and are undefined until loaded. The bench loads before fetching.
- Fetch, accepted when fetch_req=1 and FSM=IDLE:
  - idx = (A - BASE_ADDR) >> log2(DATA_W/8).
  - Next cycle: RA=mem[idx], RA_valid=1, fault=0.
  - If A is misaligned, A < BASE_ADDR, or idx >= DEPTH: RA=0, RA_valid=1, fault=1.
  - Latency is exactly 1 cycle; one fetch per cycle; RA holds its value when there is no request.
  - When no fetch is accepted, RA_valid=0 in the following cycle.
- FSM states: IDLE, LOAD, COMMIT.
  - IDLE to LOAD on prog_start. Clears word and byte indices and prog_ovf.
  - In LOAD, each prog_valid shifts prog_byte into assembly register bits [8*b +: 8], b = byte index.
  - When b reaches DATA_W/8-1, the word is written to mem[word index], the word index increments, and b returns to 0.
  - prog_valid with prog_last moves LOAD to COMMIT. A partial word is written zero-padded in its upper bytes.
  - COMMIT to IDLE after one cycle, pulsing prog_done for 1 cycle.
  - busy=1 in LOAD and COMMIT.
- Overflow: a word write with word index >= DEPTH is dropped and sets prog_ovf. The index saturates and never wraps.
- Fetch during busy: the fetch is not accepted, RA_valid=0 next cycle, and the processor must hold and retry.
- prog_start and fetch_req in the same cycle in IDLE: the fetch is accepted and completes; the load starts the same cycle.
- prog_start while in LOAD restarts the session at word 0. Words already written remain in the array.
- rst asserted mid-load aborts to IDLE. Array contents are whatever was already written.
- prog_valid in IDLE is ignored.
- Write-then-read of the same word is only reachable after COMMIT, so there is no bypass path.

Optional Feature:
IMEM_PARITY_EN
- Defined: each word stores an extra even-parity bit computed on write.
- On fetch, a parity mismatch forces fault=1 and RA=0, and sets sticky output par_err (1 bit, reset 0, cleared by prog_start).
- Not defined: no parity storage and no par_err port; array width is DATA_W.

Decomposition:
- Package imem_pkg holds:
  - FSM state enum.
  - BYTES_PER_WORD=DATA_W/8 and its log2.
  - Fault-reason localparams.
  - Function addr_to_idx(A) returning index plus a range/alignment-ok flag.
- One sub-module, imem_byte_packer: byte index counter, assembly register and word-complete strobe. Keeps the FSM and array in the top level.

Test Plan:
1. Load 8 bytes 00 00 A0 E3 04 40 A0 E3 (prog_last on byte 8), then fetch A=4 and A=8. Required: RA=E3A00000 then E3A04004, RA_valid=1 one cycle after each request, prog_done pulses once.
2. Fetch A=6, A=0, and A=BASE+4*DEPTH. Required: fault=1, RA=0 for each; then fetch A=4 gives fault=0.
3. With DEPTH=4, load 20 bytes. Required: prog_ovf=1 and word 3 holds bytes 12..15; fetch A=0x10 reads word 3 correctly.
4. Load 6 bytes. Required: word 1 reads 0000xxxx, upper two bytes zero.
5. Assert fetch_req throughout a load. Required: RA_valid=0 while busy=1, and the first valid RA appears 2 cycles after COMMIT.
6. Assert rst after 3 bytes of a load. Required: busy=0 and RA_valid=0 immediately (asynchronous); a new prog_start loads cleanly from word 0.
